trap_ctrl: RTL and testbench

//  Machine-mode trap sequencer; the initiator side of the csrs write/read port pair.
//  On ECALL it writes mepc/mcause and fetches mtvec; on MRET it fetches mepc.
//  It then issues one PC redirect to IFU. When idle it forwards EXU Zicsr accesses to csrs unchanged.

---
 rtl/trap_ctrl.sv | 78 +++++++
 tb/tb_trap_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode ECALL/MRET trap sequencer and EXU-to-csrs port forwarder
module trap_ctrl #(
    parameter int                        REG_WIDTH      = 32,
    parameter int                        CSR_ADDR_WIDTH = 12,
    parameter logic [CSR_ADDR_WIDTH-1:0] MSTATUS_ADDR   = 12'h300,
    parameter logic [CSR_ADDR_WIDTH-1:0] MTVEC_ADDR     = 12'h305,
    parameter logic [CSR_ADDR_WIDTH-1:0] MEPC_ADDR      = 12'h341,
    parameter logic [CSR_ADDR_WIDTH-1:0] MCAUSE_ADDR    = 12'h342,
    parameter logic [REG_WIDTH-1:0]      ECALL_CAUSE    = 32'd11
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ecall_in,
    input  logic                      mret_in,
    input  logic [REG_WIDTH-1:0]      pc_in,
    input  logic                      ex_csr_wr_en_in,
    input  logic [CSR_ADDR_WIDTH-1:0] ex_csr_wr_addr_in,
    input  logic [REG_WIDTH-1:0]      ex_csr_wr_data_in,
    input  logic [CSR_ADDR_WIDTH-1:0] ex_csr_rd_addr_in,
    input  logic [REG_WIDTH-1:0]      csr_rd_data_in,
    output logic                      csr_wr_en_out,
    output logic [CSR_ADDR_WIDTH-1:0] csr_wr_addr_out_1,
    output logic [REG_WIDTH-1:0]      csr_wr_data_out_1,
    output logic [CSR_ADDR_WIDTH-1:0] csr_wr_addr_out_2,
    output logic [REG_WIDTH-1:0]      csr_wr_data_out_2,
    output logic [CSR_ADDR_WIDTH-1:0] csr_rd_addr_out,
    output logic [REG_WIDTH-1:0]      ex_csr_rd_data_out,
    output logic                      busy_out,
    output logic                      redirect_valid_out,
    output logic [REG_WIDTH-1:0]      redirect_pc_out
);
    typedef enum logic [2:0] {IDLE, T_WR, T_RD, M_RD, REDIR} state_t;
    state_t                 state_q, state_d;
    logic [REG_WIDTH-1:0]   pc_q, pc_d, target_q, target_d;
    logic                   idle, unused_ok;
    assign unused_ok = ^MSTATUS_ADDR;
    assign idle = state_q == IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = ecall_in ? T_WR : mret_in ? M_RD : IDLE;
            T_WR:  state_d = T_RD;
            T_RD:  state_d = REDIR;
            M_RD:  state_d = REDIR;
            REDIR: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // Only direct-mode vectors are supported, so the low two bits are always dropped.
    always_comb begin
        pc_d     = (idle && ecall_in) ? pc_in : pc_q;
        target_d = (state_q == T_RD || state_q == M_RD) ? {csr_rd_data_in[REG_WIDTH-1:2], 2'b00} : target_q;
    end
    always_comb begin
        busy_out           = !idle;
        redirect_valid_out = state_q == REDIR;
        redirect_pc_out    = target_q;
        csr_wr_en_out      = idle ? ex_csr_wr_en_in : state_q == T_WR;
        csr_wr_addr_out_1  = idle ? ex_csr_wr_addr_in : state_q == T_WR ? MEPC_ADDR : '0;
        csr_wr_data_out_1  = idle ? ex_csr_wr_data_in : state_q == T_WR ? pc_q : '0;
        csr_wr_addr_out_2  = idle ? ex_csr_wr_addr_in : state_q == T_WR ? MCAUSE_ADDR : '0;
        csr_wr_data_out_2  = idle ? ex_csr_wr_data_in : state_q == T_WR ? ECALL_CAUSE : '0;
        csr_rd_addr_out    = idle ? ex_csr_rd_addr_in : state_q == T_RD ? MTVEC_ADDR :
                             state_q == M_RD ? MEPC_ADDR : '0;
        ex_csr_rd_data_out = idle ? csr_rd_data_in : '0;
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed scoreboard bench for trap_ctrl with a small csrs model
module tb_trap_ctrl;
    logic        clk = 0, rst = 1;
    logic        ecall_in = 0, mret_in = 0, ex_csr_wr_en_in = 0;
    logic [31:0] pc_in = 0, ex_csr_wr_data_in = 0, csr_rd_data_in;
    logic [11:0] ex_csr_wr_addr_in = 0, ex_csr_rd_addr_in = 0;
    logic        csr_wr_en_out, busy_out, redirect_valid_out;
    logic [11:0] csr_wr_addr_out_1, csr_wr_addr_out_2, csr_rd_addr_out;
    logic [31:0] csr_wr_data_out_1, csr_wr_data_out_2, ex_csr_rd_data_out, redirect_pc_out;
    logic [31:0] mtvec_m, mepc_m, mcause_m;
    int          n_assert = 0, n_fail = 0;

    typedef struct {
        string       tag;
        logic        busy, rv, we, cw, cr;
        logic [11:0] a1, a2, rd;
        logic [31:0] d1, d2, exrd, rpc;
    } exp_t;
    exp_t sb[$];

    trap_ctrl dut (
        .clk(clk), .rst(rst), .ecall_in(ecall_in), .mret_in(mret_in), .pc_in(pc_in),
        .ex_csr_wr_en_in(ex_csr_wr_en_in), .ex_csr_wr_addr_in(ex_csr_wr_addr_in),
        .ex_csr_wr_data_in(ex_csr_wr_data_in), .ex_csr_rd_addr_in(ex_csr_rd_addr_in),
        .csr_rd_data_in(csr_rd_data_in), .csr_wr_en_out(csr_wr_en_out),
        .csr_wr_addr_out_1(csr_wr_addr_out_1), .csr_wr_data_out_1(csr_wr_data_out_1),
        .csr_wr_addr_out_2(csr_wr_addr_out_2), .csr_wr_data_out_2(csr_wr_data_out_2),
        .csr_rd_addr_out(csr_rd_addr_out), .ex_csr_rd_data_out(ex_csr_rd_data_out),
        .busy_out(busy_out), .redirect_valid_out(redirect_valid_out),
        .redirect_pc_out(redirect_pc_out)
    );

    always #5 clk = ~clk;

    // csrs stand-in: combinational read, port 2 written after port 1 so it wins on a clash
    always_comb
        csr_rd_data_in = csr_rd_addr_out == 12'h305 ? mtvec_m :
                         csr_rd_addr_out == 12'h341 ? mepc_m :
                         csr_rd_addr_out == 12'h342 ? mcause_m : 32'h0;
    always @(posedge clk) begin
        if (rst) begin
            mtvec_m  <= 0;
            mepc_m   <= 0;
            mcause_m <= 32'hABCD;
        end else if (csr_wr_en_out) begin
            if (csr_wr_addr_out_1 == 12'h305) mtvec_m  <= csr_wr_data_out_1;
            if (csr_wr_addr_out_1 == 12'h341) mepc_m   <= csr_wr_data_out_1;
            if (csr_wr_addr_out_1 == 12'h342) mcause_m <= csr_wr_data_out_1;
            if (csr_wr_addr_out_2 == 12'h305) mtvec_m  <= csr_wr_data_out_2;
            if (csr_wr_addr_out_2 == 12'h341) mepc_m   <= csr_wr_data_out_2;
            if (csr_wr_addr_out_2 == 12'h342) mcause_m <= csr_wr_data_out_2;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic busy, input logic rv, input logic we,
                        input logic cw, input logic [11:0] a1, input logic [31:0] d1,
                        input logic [11:0] a2, input logic [31:0] d2, input logic cr,
                        input logic [11:0] rd, input logic [31:0] exrd, input logic [31:0] rpc);
        exp_t e;
        e.tag = tag; e.busy = busy; e.rv = rv; e.we = we; e.cw = cw; e.cr = cr;
        e.a1 = a1; e.d1 = d1; e.a2 = a2; e.d2 = d2; e.rd = rd; e.exrd = exrd; e.rpc = rpc;
        sb.push_back(e);
    endtask

    task automatic push_idle(input string tag, input logic [11:0] rd, input logic [31:0] exrd);
        push(tag, 0, 0, 0, 0, 0, 0, 0, 0, 1, rd, exrd, 0);
    endtask

    task automatic push_ecall(input string tag, input logic [31:0] pc, input logic [31:0] tgt);
        push({tag, "_twr"}, 1, 0, 1, 1, 12'h341, pc, 12'h342, 32'd11, 0, 0, 0, 0);
        push({tag, "_trd"}, 1, 0, 0, 0, 0, 0, 0, 0, 1, 12'h305, 0, 0);
        push({tag, "_redir"}, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, tgt);
    endtask

    task automatic run_cycles(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            #1;
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, ".busy"}, busy_out, e.busy);
                chk({e.tag, ".redirect_valid"}, redirect_valid_out, e.rv);
                chk({e.tag, ".wr_en"}, csr_wr_en_out, e.we);
                chk({e.tag, ".ex_rd_data"}, ex_csr_rd_data_out, e.exrd);
                if (e.cw) begin
                    chk({e.tag, ".wr_addr1"}, csr_wr_addr_out_1, e.a1);
                    chk({e.tag, ".wr_data1"}, csr_wr_data_out_1, e.d1);
                    chk({e.tag, ".wr_addr2"}, csr_wr_addr_out_2, e.a2);
                    chk({e.tag, ".wr_data2"}, csr_wr_data_out_2, e.d2);
                end
                if (e.cr) chk({e.tag, ".rd_addr"}, csr_rd_addr_out, e.rd);
                if (e.rv) chk({e.tag, ".redirect_pc"}, redirect_pc_out, e.rpc);
            end
            @(posedge clk);
            #1;
            ecall_in = 0;
            mret_in  = 0;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        push_idle("reset", 0, 0);
        chk("reset.redirect_pc", redirect_pc_out, 0);
        rst = 0;
        run_cycles(1);

        ex_csr_wr_en_in = 1; ex_csr_wr_addr_in = 12'h305; ex_csr_wr_data_in = 32'h1234;
        ex_csr_rd_addr_in = 12'h342;
        push("pass_wr", 0, 0, 1, 1, 12'h305, 32'h1234, 12'h305, 32'h1234, 1, 12'h342, 32'hABCD, 0);
        run_cycles(1);
        ex_csr_wr_data_in = 32'h8000_0103;
        push("mtvec_wr", 0, 0, 1, 1, 12'h305, 32'h8000_0103, 12'h305, 32'h8000_0103, 1, 12'h342, 32'hABCD, 0);
        run_cycles(1);
        ex_csr_wr_en_in = 0; ex_csr_rd_addr_in = 12'h305;
        push_idle("pass_rd", 12'h305, 32'h8000_0103);
        run_cycles(1);

        ex_csr_rd_addr_in = 0;
        ecall_in = 1; pc_in = 32'h8000_0010;
        push_idle("ec_acc", 0, 0);
        push_ecall("ec", 32'h8000_0010, 32'h8000_0100);
        push_idle("ec_done", 0, 0);
        run_cycles(5);

        ex_csr_wr_en_in = 1; ex_csr_wr_addr_in = 12'h341; ex_csr_wr_data_in = 32'h8000_0014;
        push("mepc_wr", 0, 0, 1, 1, 12'h341, 32'h8000_0014, 12'h341, 32'h8000_0014, 1, 0, 0, 0);
        run_cycles(1);
        ex_csr_wr_en_in = 0;
        mret_in = 1;
        push_idle("mr_acc", 0, 0);
        push("mr_rd", 1, 0, 0, 0, 0, 0, 0, 0, 1, 12'h341, 0, 0);
        push("mr_redir", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0014);
        push_idle("mr_done", 0, 0);
        run_cycles(4);

        ecall_in = 1; mret_in = 1; pc_in = 32'h8000_0020;
        push_idle("both_acc", 0, 0);
        push_ecall("both", 32'h8000_0020, 32'h8000_0100);
        push_idle("both_done0", 0, 0);
        push_idle("both_done1", 0, 0);
        run_cycles(6);

        ex_csr_wr_en_in = 1; ex_csr_wr_addr_in = 12'h300; ex_csr_wr_data_in = 32'hDEAD;
        ecall_in = 1; pc_in = 32'h8000_0030;
        push("hold_acc", 0, 0, 1, 1, 12'h300, 32'hDEAD, 12'h300, 32'hDEAD, 1, 0, 0, 0);
        push_ecall("hold", 32'h8000_0030, 32'h8000_0100);
        push("hold_done", 0, 0, 1, 1, 12'h300, 32'hDEAD, 12'h300, 32'hDEAD, 1, 0, 0, 0);
        run_cycles(5);
        ex_csr_wr_en_in = 0; ex_csr_wr_addr_in = 0; ex_csr_wr_data_in = 0;

        ecall_in = 1; pc_in = 32'h8000_0040;
        push_idle("rm_acc", 0, 0);
        push("rm_twr", 1, 0, 1, 1, 12'h341, 32'h8000_0040, 12'h342, 32'd11, 0, 0, 0, 0);
        run_cycles(2);
        rst = 1;
        push_idle("rm_rst", 0, 0);
        run_cycles(1);
        rst = 0;
        chk("rm.redirect_pc_cleared", redirect_pc_out, 0);
        push_idle("rm_after0", 0, 0);
        push_idle("rm_after1", 0, 0);
        push_idle("rm_after2", 0, 0);
        run_cycles(3);

        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
